// File: rtl/bp_update_sched_pkg.sv
// Shared types for the branch-predictor update scheduler: the buffered
// resolution record and the scheduler FSM states.
package bp_update_sched_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } bp_res_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bp_sched_state_t;

    function automatic logic is_mispredict(input logic taken, input logic pred);
        return taken ^ pred;
    endfunction

endpackage

// File: rtl/bp_res_fifo.sv
// Synchronous FIFO of resolved branch records; the extra pointer MSB
// distinguishes full from empty when the low bits match.
module bp_res_fifo
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  logic    i_pop,
    input  logic    i_flush,
    input  bp_res_t i_data,
    output logic    o_full,
    output logic    o_empty,
    output bp_res_t o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    bp_res_t     r_mem [DEPTH];

    // Pointer update; a flush wins over any coincident push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/bp_update_sched.sv
// Schedules predictor updates: clear sweep after reset/request, then FIFO
// drain of resolved branches, with saturating perf counters.
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PC_NUM_BITS   = 5,
    parameter int PC_BIT_OFFSET = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             res_valid_i,
    input  logic [31:0]      res_pc_i,
    input  logic             res_taken_i,
    input  logic             res_pred_i,
    output logic             res_ready_o,
    output logic             upd_valid_o,
    input  logic             upd_ready_i,
    output logic [31:0]      upd_pc_o,
    output logic             upd_taken_o,
    output logic             upd_clr_o,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);

    bp_sched_state_t        r_state;
    bp_sched_state_t        w_state_nxt;
    logic [PC_NUM_BITS-1:0] r_idx;
    logic [PC_NUM_BITS-1:0] w_idx_nxt;
    logic [CNT_W-1:0]       r_br_cnt;
    logic [CNT_W-1:0]       r_mp_cnt;
    logic                   r_mispred;

    logic    w_full;
    logic    w_empty;
    bp_res_t w_head;
    bp_res_t w_in;
    logic    w_run;
    logic    w_accept;
    logic    w_pop;
    logic    w_mp;

    assign w_run    = (r_state == RUN);
    assign w_accept = res_valid_i && res_ready_o;
    assign w_pop    = w_run && !w_empty && upd_ready_i;
    assign w_mp     = w_accept && is_mispredict(res_taken_i, res_pred_i);
    assign w_in     = '{pc: res_pc_i, taken: res_taken_i};

    // A push coinciding with clr_i is dropped by the flush but still counted.
    bp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (clr_i),
        .i_data  (w_in),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // FSM and sweep index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SWEEP;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state: sweep walks every index once, clr_i always restarts it.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            SWEEP: begin
                if (clr_i) begin
                    w_idx_nxt = '0;
                end else if (upd_ready_i) begin
                    if (r_idx == {PC_NUM_BITS{1'b1}}) begin
                        w_state_nxt = RUN;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + PC_NUM_BITS'(1);
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            RUN: begin
                if (clr_i) begin
                    w_state_nxt = SWEEP;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = SWEEP;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Saturating performance counters and the registered mispredict pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt  <= '0;
            r_mp_cnt  <= '0;
            r_mispred <= 1'b0;
        end else begin
            r_mispred <= w_mp;
            if (w_accept && (r_br_cnt != {CNT_W{1'b1}})) r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_mp && (r_mp_cnt != {CNT_W{1'b1}}))     r_mp_cnt <= r_mp_cnt + CNT_W'(1);
        end
    end

    assign res_ready_o     = w_run && !w_full;
    assign upd_valid_o     = !w_run || !w_empty;
    assign upd_clr_o       = !w_run;
    assign upd_pc_o        = w_run ? w_head.pc : (32'(r_idx) << PC_BIT_OFFSET);
    assign upd_taken_o     = w_run ? w_head.taken : 1'b0;
    assign mispredict_o    = r_mispred;
    assign br_count_o      = r_br_cnt;
    assign mispred_count_o = r_mp_cnt;

endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: directed scenarios plus a random
// phase, all compared against a queue-based behavioural model.
module tb_bp_update_sched;

    localparam int DEPTH = 4;
    localparam int NIDX  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_i = 1'b0;
    logic        res_valid_i = 1'b0;
    logic [31:0] res_pc_i = 32'h0;
    logic        res_taken_i = 1'b0;
    logic        res_pred_i = 1'b0;
    logic        upd_ready_i = 1'b0;
    logic        res_ready_o;
    logic        upd_valid_o;
    logic [31:0] upd_pc_o;
    logic        upd_taken_o;
    logic        upd_clr_o;
    logic        mispredict_o;
    logic [CNT_W-1:0] br_count_o;
    logic [CNT_W-1:0] mispred_count_o;

    bp_update_sched #(.DEPTH(DEPTH), .PC_NUM_BITS(5), .PC_BIT_OFFSET(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr_i(clr_i),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i),
        .res_taken_i(res_taken_i), .res_pred_i(res_pred_i),
        .res_ready_o(res_ready_o), .upd_valid_o(upd_valid_o),
        .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
        .upd_taken_o(upd_taken_o), .upd_clr_o(upd_clr_o),
        .mispredict_o(mispredict_o), .br_count_o(br_count_o),
        .mispred_count_o(mispred_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    bit          m_sweep;
    int          m_idx;
    logic [32:0] m_q[$];
    int          m_br;
    int          m_mp;
    bit          m_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sweep = 1'b1;
        m_idx   = 0;
        m_q.delete();
        m_br    = 0;
        m_mp    = 0;
        m_pulse = 1'b0;
    endtask

    function automatic bit m_ready();
        return !m_sweep && (m_q.size() < DEPTH);
    endfunction

    function automatic bit m_valid();
        return m_sweep || (m_q.size() > 0);
    endfunction

    task automatic check_all();
        logic [32:0] h;
        chk("res_ready", 32'(res_ready_o), 32'(m_ready()));
        chk("upd_valid", 32'(upd_valid_o), 32'(m_valid()));
        if (m_valid()) begin
            chk("upd_clr", 32'(upd_clr_o), 32'(m_sweep));
            if (m_sweep) begin
                chk("sweep_pc", upd_pc_o, 32'(m_idx * 4));
            end else begin
                h = m_q[0];
                chk("upd_pc", upd_pc_o, h[32:1]);
                chk("upd_taken", 32'(upd_taken_o), 32'(h[0]));
            end
        end
        chk("mispredict", 32'(mispredict_o), 32'(m_pulse));
        chk("br_count", 32'(br_count_o), 32'(m_br));
        chk("mp_count", 32'(mispred_count_o), 32'(m_mp));
    endtask

    // One cycle: check current outputs, clock, then advance the model.
    task automatic step();
        bit acc, hs;
        check_all();
        acc = res_valid_i && m_ready();
        hs  = m_valid() && upd_ready_i;
        @(posedge clk);
        m_pulse = acc && (res_taken_i != res_pred_i);
        if (acc) begin
            if (m_br < CMAX) m_br++;
            if (res_taken_i != res_pred_i && m_mp < CMAX) m_mp++;
        end
        if (m_sweep) begin
            if (clr_i) m_idx = 0;
            else if (hs) begin
                if (m_idx == NIDX - 1) begin
                    m_sweep = 1'b0;
                    m_idx = 0;
                end else m_idx++;
            end
        end else if (clr_i) begin
            m_q.delete();
            m_sweep = 1'b1;
            m_idx = 0;
        end else begin
            if (hs) void'(m_q.pop_front());
            if (acc) m_q.push_back({res_pc_i, res_taken_i});
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit t, input bit p);
        res_valid_i = v;
        res_pc_i    = pc;
        res_taken_i = t;
        res_pred_i  = p;
    endtask

    task automatic check_reset_values();
        chk("rst_ready", 32'(res_ready_o), 32'd0);
        chk("rst_valid", 32'(upd_valid_o), 32'd1);
        chk("rst_clr", 32'(upd_clr_o), 32'd1);
        chk("rst_pc", upd_pc_o, 32'h0);
        chk("rst_mispredict", 32'(mispredict_o), 32'd0);
        chk("rst_br", 32'(br_count_o), 32'd0);
        chk("rst_mp", 32'(mispred_count_o), 32'd0);
    endtask

    initial begin
        model_reset();
        #2;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
        upd_ready_i = 1'b1;

        // Power-up sweep: 32 clear handshakes, then RUN
        for (int i = 0; i < NIDX; i++) step();
        chk("run_entered", 32'(res_ready_o), 32'd1);

        // Stall predictor, offer 5 pushes: 4 fit, 5th held off
        upd_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), i[0], i[0]);
            step();
        end
        chk("full_ready_low", 32'(res_ready_o), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        upd_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Mispredict pulse and update content
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        upd_ready_i = 1'b0;
        step();
        step();

        // Clear with two entries queued, then sweep part-way
        upd_ready_i = 1'b1;
        step();
        upd_ready_i = 1'b0;
        drive(1'b1, 32'h200, 1'b1, 1'b1); step();
        drive(1'b1, 32'h204, 1'b0, 1'b1); step();
        drive(1'b1, 32'h208, 1'b1, 1'b1);
        clr_i = 1'b1; step();
        clr_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        upd_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Asynchronous reset between edges at sweep idx 10
        chk("pre_rst_pc", upd_pc_o, 32'h28);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values();
        #2;
        rst = 1'b0;
        for (int i = 0; i < NIDX; i++) step();

        // Random traffic, exercising saturation, clears and back-pressure
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 1) == 1), $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
            upd_ready_i = ($urandom_range(0, 3) != 0);
            clr_i = ($urandom_range(0, 99) == 0);
            step();
        end
        clr_i = 1'b0;
        chk("br_saturated", 32'(br_count_o), 32'(CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
